pe_uop_sequencer: RTL and testbench
===================================

Name: pe_uop_sequencer

Overview:
- Issue side of the PE micro-op interface: accepts one convolution job (kernel length, optional bias, optional ReLU) plus an x/weight operand stream.
- Drives the single-cycle uop bus (flush, in_valid, calc_bias, calc_relu, out_en, x, weight) into one PE.
- Captures the PE result when the PE flags it valid and returns it on a ready/valid result port with an error flag.
- Sits between the tile controller / operand buffers and each PE.

Parameters:
- LEN_W, 8, width of job_len; max kernel length 2^LEN_W-1.
- Data width is `XLEN (`DATA_RANGE) from defines.sv.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- job_valid  in  1  job request.
- job_ready  out  1  high only in IDLE.
- job_len  in  LEN_W  number of MAC terms; 0 is legal.
- job_bias  in  1  add bias after the MACs.
- job_bias_val  in  `XLEN  signed bias value.
- job_relu  in  1  apply ReLU after bias.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  high in MAC while terms remain.
- op_x  in  `XLEN  activation.
- op_w  in  `XLEN  weight.
- pe_x  out  `XLEN  to PE x.
- pe_weight  out  `XLEN  to PE weight.
- pe_in_valid, pe_flush, pe_out_en, pe_calc_bias, pe_calc_relu  out  1 each  PE uop bits.
- pe_result  in  `XLEN  PE result_out.
- pe_out_valid  in  1  PE out_valid_r.
- pe_illegal_uop  in  1  PE illegal_uop.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  `XLEN  captured result.
- res_err  out  1  protocol error for this job.

Behaviour:
- Uop register: every cycle the uop decided by the current state is loaded into the pe_* registers. A uop decided in cycle n is on pe_* in n+1; the matching pe_out_valid appears in n+2. A cycle with no uop decides all-zero (PE hold).
- Reset (rst=1 at a clock edge, including mid-job):
  - state = IDLE.
  - All pe_* outputs = 0; res_valid = 0; res_data = 0; res_err = 0; op_ready = 0; err flag cleared.
  - Any in-flight job is dropped. The next job's FLUSH clears the PE.
- IDLE:
  - job_ready = 1.
  - On job_valid, latch len, bias, bias_val and relu; clear the err flag; go to FLUSH.
- FLUSH (1 cycle): uop flush=1, all other bits 0. Next state is MAC if len>0, else BIAS / RELU / OUT in that order of enablement.
- MAC:
  - op_ready = 1.
  - On op_valid & op_ready: uop in_valid=1, x=op_x, weight=op_w; decrement the remaining count.
  - op_valid=0 is a stall: all-zero uop, no count change.
  - Leave MAC after the last accepted pair.
- BIAS (if job_bias, 1 cycle): in_valid=1, calc_bias=1, x=0, weight=bias_val.
- RELU (if job_relu, 1 cycle): calc_relu=1, in_valid=0.
- OUT (1 cycle): out_en=1 only.
- WAIT (exactly 2 cycles):
  - In the second cycle, sample pe_out_valid.
  - If 1: res_data <= pe_result. If 0: res_data <= pe_result and set the err flag.
  - Go to RESP.
- RESP:
  - res_valid = 1; res_data and res_err are held stable.
  - res_err = err flag.
  - On res_ready, go to IDLE. job_ready rises the cycle after the handshake.
- Illegal uop monitoring: pe_illegal_uop sampled high in any cycle from FLUSH through WAIT sets the sticky err flag. The sequencer never issues combinations 001?? or 01?1?.
- Arithmetic lives in the PE, which uses signed two's-complement wrap at `XLEN. The sequencer is data-transparent.
- Stale pe_out_valid from the previous job is ignored outside the WAIT sample cycle. FLUSH and MAC clear it in the PE.
- Nominal latency (no stalls, OUT not merged): job accepted in cycle 0 → res_valid in cycle len + bias + relu + 5.

Optional Feature:
- Macro: PE_OUT_MERGE_EN.
- Defined:
  - out_en is ORed into the last uop of the job: the last MAC, BIAS or RELU.
  - OUT is skipped, unless len=0 and no bias and no relu.
  - Latency is reduced by 1 cycle. WAIT still samples 2 cycles after the out_en-carrying uop.
- Undefined: separate OUT state, always.

Test Plan:
- len=3, x={1,2,3}, w={4,5,6}, no bias/relu, res_ready=1 → res_data=32, res_err=0, res_valid in cycle 8 (7 with PE_OUT_MERGE_EN).
- Same operands, bias=-40, relu=1 → res_data=0. Same with relu=0 → res_data=-8 (0xFFFFFFF8 for XLEN=32).
- len=0, bias=7, relu=0 → uop sequence FLUSH, BIAS, OUT; res_data=7.
- len=2, op_valid low for 3 cycles between pairs, x={-2,5}, w={3,3} → pe_in_valid pulses exactly twice, res_data=9, latency +3.
- res_ready held low for 4 cycles → res_valid and res_data stable for 4 cycles, job_ready=0 throughout; a new job is accepted only after the handshake.
- rst=1 mid-MAC → next cycle all outputs 0, state IDLE. A following job len=1, x=2, w=3 → res_data=6 (flush clears stale accumulation).

Source files
------------

// File: rtl/pe_uop_sequencer.sv
// pe_uop_sequencer: issues one PE's micro-op stream for a convolution job and returns its result.
// Optional build macro PE_OUT_MERGE_EN folds out_en into the job's last uop and skips the OUT step.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef DATA_RANGE
`define DATA_RANGE `XLEN-1:0
`endif

module pe_uop_sequencer #(
   parameter int LEN_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [LEN_W-1:0]   job_len,
   input  logic               job_bias,
   input  logic [`DATA_RANGE] job_bias_val,
   input  logic               job_relu,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [`DATA_RANGE] op_x,
   input  logic [`DATA_RANGE] op_w,
   output logic [`DATA_RANGE] pe_x,
   output logic [`DATA_RANGE] pe_weight,
   output logic               pe_in_valid,
   output logic               pe_flush,
   output logic               pe_out_en,
   output logic               pe_calc_bias,
   output logic               pe_calc_relu,
   input  logic [`DATA_RANGE] pe_result,
   input  logic               pe_out_valid,
   input  logic               pe_illegal_uop,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [`DATA_RANGE] res_data,
   output logic               res_err
);

`ifdef PE_OUT_MERGE_EN
   localparam bit MERGE_EN = 1'b1;
`else
   localparam bit MERGE_EN = 1'b0;
`endif

   typedef enum logic [3:0] {
      S_IDLE,
      S_FLUSH,
      S_MAC,
      S_BIAS,
      S_RELU,
      S_OUT,
      S_WAIT1,
      S_WAIT2,
      S_RESP
   } state_t;

   state_t state, state_nxt;
   state_t after_mac, after_bias, after_relu;

   logic [LEN_W-1:0]   len_left, len_left_nxt;
   logic               bias_r, relu_r, err_r;
   logic [`DATA_RANGE] bias_val_r;
   logic               in_job;

   logic               uop_flush, uop_in_valid, uop_calc_bias, uop_calc_relu, uop_out_en;
   logic [`DATA_RANGE] uop_x, uop_w;

   // Successor of each compute step depends on which later steps the job enabled.
   always_comb begin
      after_relu = MERGE_EN ? S_WAIT1 : S_OUT;
      after_bias = relu_r ? S_RELU : after_relu;
      after_mac  = bias_r ? S_BIAS : after_bias;
   end

   assign in_job  = (state != S_IDLE) && (state != S_RESP);
   assign res_err = err_r;

   always_comb begin
      state_nxt     = state;
      len_left_nxt  = len_left;
      job_ready     = 1'b0;
      op_ready      = 1'b0;
      res_valid     = 1'b0;
      uop_flush     = 1'b0;
      uop_in_valid  = 1'b0;
      uop_calc_bias = 1'b0;
      uop_calc_relu = 1'b0;
      uop_out_en    = 1'b0;
      uop_x         = '0;
      uop_w         = '0;
      case (state)
         S_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) begin
               len_left_nxt = job_len;
               state_nxt    = S_FLUSH;
            end
         end
         S_FLUSH: begin
            uop_flush = 1'b1;
            if (len_left != '0)
               state_nxt = S_MAC;
            else if (bias_r)
               state_nxt = S_BIAS;
            else if (relu_r)
               state_nxt = S_RELU;
            else
               state_nxt = S_OUT;
         end
         S_MAC: begin
            op_ready = 1'b1;
            if (op_valid) begin
               uop_in_valid = 1'b1;
               uop_x        = op_x;
               uop_w        = op_w;
               len_left_nxt = len_left - LEN_W'(1);
               if (len_left == LEN_W'(1)) begin
                  uop_out_en = MERGE_EN && !bias_r && !relu_r;
                  state_nxt  = after_mac;
               end
            end
         end
         S_BIAS: begin
            uop_in_valid  = 1'b1;
            uop_calc_bias = 1'b1;
            uop_w         = bias_val_r;
            uop_out_en    = MERGE_EN && !relu_r;
            state_nxt     = after_bias;
         end
         S_RELU: begin
            uop_calc_relu = 1'b1;
            uop_out_en    = MERGE_EN;
            state_nxt     = after_relu;
         end
         S_OUT: begin
            uop_out_en = 1'b1;
            state_nxt  = S_WAIT1;
         end
         S_WAIT1: state_nxt = S_WAIT2;
         S_WAIT2: state_nxt = S_RESP;
         S_RESP: begin
            res_valid = 1'b1;
            if (res_ready)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // The PE result is valid two cycles after out_en was decided; WAIT2 is that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         len_left     <= '0;
         bias_r       <= 1'b0;
         relu_r       <= 1'b0;
         bias_val_r   <= '0;
         err_r        <= 1'b0;
         res_data     <= '0;
         pe_flush     <= 1'b0;
         pe_in_valid  <= 1'b0;
         pe_calc_bias <= 1'b0;
         pe_calc_relu <= 1'b0;
         pe_out_en    <= 1'b0;
         pe_x         <= '0;
         pe_weight    <= '0;
      end else begin
         state        <= state_nxt;
         len_left     <= len_left_nxt;
         pe_flush     <= uop_flush;
         pe_in_valid  <= uop_in_valid;
         pe_calc_bias <= uop_calc_bias;
         pe_calc_relu <= uop_calc_relu;
         pe_out_en    <= uop_out_en;
         pe_x         <= uop_x;
         pe_weight    <= uop_w;
         if (state == S_IDLE && job_valid) begin
            bias_r     <= job_bias;
            bias_val_r <= job_bias_val;
            relu_r     <= job_relu;
            err_r      <= 1'b0;
         end
         if (in_job && pe_illegal_uop)
            err_r <= 1'b1;
         if (state == S_WAIT2) begin
            res_data <= pe_result;
            if (!pe_out_valid)
               err_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pe_uop_sequencer.sv
// tb_pe_uop_sequencer: drives directed and random jobs through pe_uop_sequencer with a stub PE,
// comparing results, latency and the issued uop stream against a reference computed from job rules.

`ifndef XLEN
`define XLEN 32
`endif

module tb_pe_uop_sequencer;

   localparam int LEN_W = 8;
`ifdef PE_OUT_MERGE_EN
   localparam bit MERGE = 1'b1;
`else
   localparam bit MERGE = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               job_valid = 1'b0;
   logic               job_ready;
   logic [LEN_W-1:0]   job_len = '0;
   logic               job_bias = 1'b0;
   logic [31:0]        job_bias_val = '0;
   logic               job_relu = 1'b0;
   logic               op_valid = 1'b0;
   logic               op_ready;
   logic [31:0]        op_x = '0;
   logic [31:0]        op_w = '0;
   logic signed [31:0] pe_x, pe_weight;
   logic               pe_in_valid, pe_flush, pe_out_en, pe_calc_bias, pe_calc_relu;
   logic [31:0]        pe_result = '0;
   logic               pe_out_valid = 1'b0;
   logic               pe_illegal_uop;
   logic               res_valid;
   logic               res_ready = 1'b0;
   logic [31:0]        res_data;
   logic               res_err;

   bit                 drop_valid = 1'b0;
   bit                 inject_illegal = 1'b0;
   logic signed [31:0] pe_acc;
   int                 cyc = 0;
   logic [68:0]        trace[$];
   logic signed [31:0] xs[$], ws[$];
   int                 total = 0;
   int                 bad = 0;

   pe_uop_sequencer #(.LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
      .job_bias(job_bias), .job_bias_val(job_bias_val), .job_relu(job_relu),
      .op_valid(op_valid), .op_ready(op_ready), .op_x(op_x), .op_w(op_w),
      .pe_x(pe_x), .pe_weight(pe_weight), .pe_in_valid(pe_in_valid), .pe_flush(pe_flush),
      .pe_out_en(pe_out_en), .pe_calc_bias(pe_calc_bias), .pe_calc_relu(pe_calc_relu),
      .pe_result(pe_result), .pe_out_valid(pe_out_valid), .pe_illegal_uop(pe_illegal_uop),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
   );

   initial forever #5 clk = ~clk;

   // Stub PE: accumulates MACs, adds bias, clamps on ReLU and publishes on out_en.
   // It is deliberately not reset by rst, so only the job's FLUSH can clear stale state.
   always @(posedge clk) begin
      logic signed [31:0] a;
      a = pe_acc;
      if (pe_flush)
         a = 0;
      else if (pe_in_valid && pe_calc_bias)
         a = a + pe_weight;
      else if (pe_in_valid)
         a = a + pe_x * pe_weight;
      if (pe_calc_relu && a < 0)
         a = 0;
      pe_acc <= a;
      if (pe_flush || (pe_in_valid && !pe_calc_bias))
         pe_out_valid <= 1'b0;
      if (pe_out_en) begin
         pe_result    <= a;
         pe_out_valid <= !drop_valid;
      end
   end

   assign pe_illegal_uop = inject_illegal ||
      (!pe_flush && ((!pe_in_valid && pe_calc_bias) || (pe_in_valid && pe_calc_relu)));

   // Cycle counter plus a log of every non-hold uop the PE actually received.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if ({pe_flush, pe_in_valid, pe_calc_bias, pe_calc_relu, pe_out_en} != 5'b0)
         trace.push_back({pe_flush, pe_in_valid, pe_calc_bias, pe_calc_relu, pe_out_en, pe_x, pe_weight});
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input string what, input logic [71:0] obs,
                              input logic [71:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s/%s: observed %0h expected %0h", tag, what, obs, exp);
      end
   endtask

   task automatic fillRandom(input int len);
      xs.delete();
      ws.delete();
      for (int k = 0; k < len; k++) begin
         xs.push_back($urandom);
         ws.push_back($urandom);
      end
   endtask

   // Runs one whole job using xs/ws as operands and checks result, latency, handshake and uop stream.
   task automatic applyStimulus(input string tag, input int len, input bit bias,
                                input logic signed [31:0] bval, input bit relu, input int gap,
                                input bit rand_stall, input int hold, input bit drop, input bit inject);
      logic signed [31:0] acc;
      logic [31:0]        exp_data;
      logic [68:0]        et[$];
      int                 start, lat, n, i, gap_left, stalls, t0, got;
      bit                 out_sep;

      acc = 0;
      for (int k = 0; k < len; k++)
         acc = acc + xs[k] * ws[k];
      if (bias)
         acc = acc + bval;
      if (relu && acc < 0)
         acc = 0;
      exp_data = acc;

      out_sep = !MERGE || (len == 0 && !bias && !relu);
      et.push_back({5'b10000, 64'd0});
      for (int k = 0; k < len; k++)
         et.push_back({4'b0100, (MERGE && k == len - 1 && !bias && !relu), xs[k], ws[k]});
      if (bias)
         et.push_back({4'b0110, (MERGE && !relu), 32'd0, bval});
      if (relu)
         et.push_back({4'b0001, MERGE, 64'd0});
      if (out_sep)
         et.push_back({5'b00001, 64'd0});
      lat = len + int'(bias) + int'(relu) + 5 - (out_sep ? 0 : 1);

      checkOutput(tag, "job_ready_idle", 72'(job_ready), 72'(1));
      t0           = trace.size();
      drop_valid   = drop;
      job_len      = LEN_W'(len);
      job_bias     = bias;
      job_bias_val = bval;
      job_relu     = relu;
      job_valid    = 1'b1;
      start        = cyc;
      @(negedge clk);
      job_valid = 1'b0;

      i = 0; n = 0; gap_left = 0; stalls = 0;
      while (!res_valid && n < 3000) begin
         inject_illegal = inject && (n == 1);
         op_valid = 1'b0;
         if (op_ready && i < len) begin
            if (gap_left > 0) begin
               gap_left--;
               stalls++;
            end else if (rand_stall && $urandom_range(0, 3) == 0) begin
               stalls++;
            end else begin
               op_valid = 1'b1;
               op_x     = xs[i];
               op_w     = ws[i];
               i++;
               gap_left = gap;
            end
         end
         @(negedge clk);
         n++;
      end
      op_valid       = 1'b0;
      inject_illegal = 1'b0;

      checkOutput(tag, "res_valid_seen", 72'(res_valid), 72'(1));
      checkOutput(tag, "latency", 72'(cyc - start), 72'(lat + stalls));
      checkOutput(tag, "res_data", 72'(res_data), 72'(exp_data));
      checkOutput(tag, "res_err", 72'(res_err), 72'(drop || inject));

      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checkOutput(tag, "hold_res_valid", 72'(res_valid), 72'(1));
         checkOutput(tag, "hold_res_data", 72'(res_data), 72'(exp_data));
         checkOutput(tag, "hold_job_ready", 72'(job_ready), 72'(0));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput(tag, "post_res_valid", 72'(res_valid), 72'(0));
      checkOutput(tag, "post_job_ready", 72'(job_ready), 72'(1));

      got = trace.size() - t0;
      checkOutput(tag, "uop_count", 72'(got), 72'(et.size()));
      for (int k = 0; k < et.size() && k < got; k++)
         checkOutput(tag, "uop", 72'(trace[t0 + k]), 72'(et[k]));
      drop_valid = 1'b0;
   endtask

   initial begin
      int rlen, k, n;
      bit rb, rr;

      $display("[TB] start, merge=%0d", MERGE);
      repeat (3) @(negedge clk);
      checkOutput("reset", "pe_flush", 72'(pe_flush), 72'(0));
      checkOutput("reset", "pe_in_valid", 72'(pe_in_valid), 72'(0));
      checkOutput("reset", "pe_out_en", 72'(pe_out_en), 72'(0));
      checkOutput("reset", "pe_x", 72'($unsigned(pe_x)), 72'(0));
      checkOutput("reset", "res_valid", 72'(res_valid), 72'(0));
      checkOutput("reset", "res_data", 72'(res_data), 72'(0));
      checkOutput("reset", "res_err", 72'(res_err), 72'(0));
      checkOutput("reset", "op_ready", 72'(op_ready), 72'(0));
      checkOutput("reset", "job_ready", 72'(job_ready), 72'(1));
      rst = 1'b0;
      @(negedge clk);

      xs = '{32'sd1, 32'sd2, 32'sd3};
      ws = '{32'sd4, 32'sd5, 32'sd6};
      applyStimulus("dot3", 3, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("bias_relu", 3, 1, -32'sd40, 1, 0, 0, 0, 0, 0);
      applyStimulus("bias_norelu", 3, 1, -32'sd40, 0, 0, 0, 0, 0, 0);
      applyStimulus("hold4", 3, 0, 0, 0, 0, 0, 4, 0, 0);
      applyStimulus("relu_pos", 3, 0, 0, 1, 0, 0, 0, 0, 0);

      xs.delete(); ws.delete();
      applyStimulus("len0_bias", 0, 1, 32'sd7, 0, 0, 0, 0, 0, 0);
      applyStimulus("len0_bare", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus("len0_relu", 0, 1, -32'sd5, 1, 0, 0, 0, 0, 0);

      xs = '{-32'sd2, 32'sd5};
      ws = '{32'sd3, 32'sd3};
      applyStimulus("stall3", 2, 0, 0, 0, 3, 0, 0, 0, 0);
      applyStimulus("no_out_valid", 2, 0, 0, 0, 0, 0, 0, 1, 0);
      applyStimulus("illegal", 2, 1, 32'sd1, 0, 0, 0, 0, 0, 1);
      applyStimulus("err_cleared", 2, 0, 0, 0, 0, 0, 0, 0, 0);

      // Abort a job in the middle of its MAC phase.
      job_len   = LEN_W'(5);
      job_bias  = 1'b0;
      job_relu  = 1'b0;
      job_valid = 1'b1;
      @(negedge clk);
      job_valid = 1'b0;
      k = 0; n = 0;
      while (k < 2 && n < 20) begin
         op_valid = 1'b0;
         if (op_ready) begin
            op_valid = 1'b1;
            op_x     = 32'd7;
            op_w     = 32'd9;
            k++;
         end
         @(negedge clk);
         n++;
      end
      op_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid", "pe_in_valid", 72'(pe_in_valid), 72'(0));
      checkOutput("rst_mid", "pe_x", 72'($unsigned(pe_x)), 72'(0));
      checkOutput("rst_mid", "pe_weight", 72'($unsigned(pe_weight)), 72'(0));
      checkOutput("rst_mid", "pe_flush", 72'(pe_flush), 72'(0));
      checkOutput("rst_mid", "res_data", 72'(res_data), 72'(0));
      checkOutput("rst_mid", "res_valid", 72'(res_valid), 72'(0));
      checkOutput("rst_mid", "op_ready", 72'(op_ready), 72'(0));
      checkOutput("rst_mid", "job_ready", 72'(job_ready), 72'(1));
      rst = 1'b0;
      xs = '{32'sd2};
      ws = '{32'sd3};
      applyStimulus("after_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int j = 0; j < 10; j++) begin
         rlen = $urandom_range(0, 6);
         rb   = ($urandom_range(0, 1) == 1);
         rr   = ($urandom_range(0, 1) == 1);
         fillRandom(rlen);
         applyStimulus("rand", rlen, rb, $urandom, rr, 0, 1, $urandom_range(0, 3), 0, 0);
      end

      fillRandom(255);
      applyStimulus("len_max", 255, 1, $urandom, 1, 0, 1, 1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
